// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/result and word-bus handshake signals of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    output stall, load_valid, load_data, fault, fault_code, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    input  stall, load_valid, load_data, fault, fault_code, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage unit turning RISC-V loads/stores into a strobed word-bus grant/response transaction
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t      r_state;
  logic        r_we;
  logic        r_bus_req;
  logic        r_load_valid;
  logic        r_fault;
  logic [1:0]  r_code;
  logic [2:0]  r_f3;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        w_legal;
  logic        w_mis;
  logic [31:0] w_shift;
  logic [31:0] w_ld;
  assign w_legal = (bus.req_funct3 < 3'd3) || (!bus.req_we && (bus.req_funct3 == 3'd4 || bus.req_funct3 == 3'd5));
  assign w_mis = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign w_shift = bus.bus_rdata >> {r_addr[1:0], 3'b000};
  assign w_ld = r_f3 == 3'b000 ? {{24{w_shift[7]}}, w_shift[7:0]} :
                r_f3 == 3'b100 ? {24'd0, w_shift[7:0]} :
                r_f3 == 3'b001 ? {{16{w_shift[15]}}, w_shift[15:0]} :
                r_f3 == 3'b101 ? {16'd0, w_shift[15:0]} : bus.bus_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_we <= 1'b0;
      r_bus_req <= 1'b0;
      r_load_valid <= 1'b0;
      r_fault <= 1'b0;
      r_code <= 2'b00;
      r_f3 <= 3'b000;
      r_cnt <= 16'd0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_load_data <= 32'd0;
    end else begin
      r_load_valid <= 1'b0;
      r_fault <= 1'b0;
      r_code <= 2'b00;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_we <= bus.req_we;
          r_f3 <= bus.req_funct3;
          r_addr <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          if (!w_legal || w_mis) begin
            r_state <= DONE;
            r_fault <= 1'b1;
            r_code <= w_legal ? 2'b01 : 2'b10;
            r_load_data <= 32'd0;
          end else begin
            r_state <= REQ;
            r_bus_req <= 1'b1;
          end
        end
        REQ: if (bus.bus_gnt) begin
          r_bus_req <= 1'b0;
          r_cnt <= 16'd0;
          r_state <= r_we ? DONE : RESP;
        end
        RESP: begin
          r_cnt <= r_cnt + 16'd1;
          if (bus.bus_rvalid) begin
            r_load_data <= w_ld;
            r_load_valid <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_fault <= 1'b1;
            r_code <= 2'b11;
            r_load_data <= 32'd0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.stall = bus.req_valid && r_state != DONE;
  assign bus.load_valid = r_load_valid;
  assign bus.load_data = r_load_data;
  assign bus.fault = r_fault;
  assign bus.fault_code = r_code;
  assign bus.bus_req = r_bus_req;
  assign bus.bus_we = r_we;
  assign bus.bus_addr = {r_addr[31:2], 2'b00};
  assign bus.bus_wstrb = !r_we ? 4'b0000 :
                         r_f3[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0] :
                         r_f3[1:0] == 2'b01 ? 4'b0011 << r_addr[1:0] : 4'b1111;
  assign bus.bus_wdata = r_f3[1:0] == 2'b00 ? {4{r_wdata[7:0]}} :
                         r_f3[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against a byte-level model of the load/store unit
module tb_load_store_unit;
  localparam int TMO = 4;
  logic clk;
  logic reset;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] exp_ld = 32'd0;
  load_store_unit_if bif();
  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bif));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_cycle(input logic stray);
    bif.req_valid = 1'b0;
    bif.bus_gnt = stray;
    bif.bus_rvalid = stray;
    bif.bus_rdata = $urandom;
    @(negedge clk);
    chk("idle_quiet", {28'd0, bif.stall, bif.load_valid, bif.fault, bif.bus_req}, 32'd0);
    chk("idle_load_data", bif.load_data, exp_ld);
    @(posedge clk);
    #1;
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
  endtask
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gdly, input int rdly, input logic [31:0] rdata);
    int size, o, nst, nreq, ridx, est, ereq;
    logic [1:0] ecode;
    logic [3:0] estrb;
    logic [31:0] ewd, eld;
    logic legal, in_resp, done;
    size = 1 << f3[1:0];
    o = int'(addr % 4);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    ecode = !legal ? 2'd2 : (addr % size != 0) ? 2'd1 : (!we && rdly >= TMO) ? 2'd3 : 2'd0;
    for (int b = 0; b < 4; b++) begin
      estrb[b] = we && b >= o && b < o + size;
      ewd[8*b +: 8] = wdata[8*(b % size) +: 8];
    end
    eld = rdata >> (8 * o);
    if (f3 == 3'd2) eld = rdata;
    else if (size == 1) begin
      eld = eld % 256;
      if (f3 == 3'd0 && eld >= 128) eld = eld + 32'hFFFF_FF00;
    end else begin
      eld = eld % 65536;
      if (f3 == 3'd1 && eld >= 32768) eld = eld + 32'hFFFF_0000;
    end
    est = (ecode == 2'd1 || ecode == 2'd2) ? 1 : 2 + gdly + (we ? 0 : (ecode == 2'd3 ? TMO : rdly + 1));
    ereq = (ecode == 2'd1 || ecode == 2'd2) ? 0 : gdly + 1;
    bif.req_valid = 1'b1;
    bif.req_we = we;
    bif.req_funct3 = f3;
    bif.req_addr = addr;
    bif.req_wdata = wdata;
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    nst = 0;
    nreq = 0;
    ridx = 0;
    in_resp = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!bif.stall) begin
        done = 1'b1;
        chk("stall_cycles", nst, est);
        chk("req_cycles", nreq, ereq);
        chk("fault", {31'd0, bif.fault}, {31'd0, ecode != 2'd0});
        chk("fault_code", {30'd0, bif.fault_code}, {30'd0, ecode});
        chk("load_valid", {31'd0, bif.load_valid}, {31'd0, !we && ecode == 2'd0});
        if (ecode != 2'd0) exp_ld = 32'd0;
        else if (!we) exp_ld = eld;
        chk("load_data", bif.load_data, exp_ld);
      end else begin
        nst++;
        chk("no_early_pulse", {30'd0, bif.load_valid, bif.fault}, 32'd0);
        if (bif.bus_req) begin
          nreq++;
          chk("bus_addr", bif.bus_addr, addr & 32'hFFFF_FFFC);
          chk("bus_we", {31'd0, bif.bus_we}, {31'd0, we});
          chk("bus_wstrb", {28'd0, bif.bus_wstrb}, {28'd0, estrb});
          if (we) chk("bus_wdata", bif.bus_wdata, ewd);
          bif.bus_gnt = (nreq == gdly + 1);
        end else if (in_resp) begin
          bif.bus_rvalid = (ridx == rdly);
          bif.bus_rdata = bif.bus_rvalid ? rdata : $urandom;
          ridx++;
        end
      end
      @(posedge clk);
      #1;
      if (bif.bus_gnt && !we) in_resp = 1'b1;
      bif.bus_gnt = 1'b0;
      bif.bus_rvalid = 1'b0;
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
  endtask
  initial begin
    reset = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_we = 1'b0;
    bif.req_funct3 = 3'd0;
    bif.req_addr = 32'd0;
    bif.req_wdata = 32'd0;
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {23'd0, bif.stall, bif.load_valid, bif.fault, bif.fault_code, bif.bus_req, bif.bus_we, bif.bus_wstrb != 4'd0}, 32'd0);
    chk("reset_load_data", bif.load_data, 32'd0);
    chk("reset_bus_addr", bif.bus_addr, 32'd0);
    @(posedge clk);
    #1;
    access(1'b0, 3'd2, 32'h100, 32'd0, 0, 0, 32'hDEAD_BEEF);
    chk("lw_const", bif.load_data, 32'hDEAD_BEEF);
    access(1'b0, 3'd0, 32'h203, 32'd0, 0, 0, 32'h8011_2233);
    chk("lb_const", bif.load_data, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h203, 32'd0, 0, 1, 32'h8011_2233);
    chk("lbu_const", bif.load_data, 32'h0000_0080);
    access(1'b1, 3'd1, 32'h306, 32'h1234_ABCD, 4, 0, 32'd0);
    access(1'b0, 3'd2, 32'h102, 32'd0, 0, 0, 32'h1111_1111);
    chk("mis_const", bif.load_data, 32'd0);
    access(1'b0, 3'd3, 32'h100, 32'd0, 0, 0, 32'h1111_1111);
    access(1'b0, 3'd5, 32'h042, 32'd0, 1, 2, 32'h9876_5432);
    chk("lhu_const", bif.load_data, 32'h0000_9876);
    access(1'b0, 3'd2, 32'h500, 32'd0, 1, 9, 32'h2222_2222);
    idle_cycle(1'b1);
    bif.req_valid = 1'b1;
    bif.req_we = 1'b0;
    bif.req_funct3 = 3'd2;
    bif.req_addr = 32'h400;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_test_req", {31'd0, bif.bus_req}, 32'd1);
    bif.bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    bif.bus_gnt = 1'b0;
    reset = 1'b1;
    bif.req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata = 32'h1234_5678;
    exp_ld = 32'd0;
    @(negedge clk);
    chk("midrst_ctrl", {23'd0, bif.stall, bif.load_valid, bif.fault, bif.fault_code, bif.bus_req, bif.bus_we, bif.bus_wstrb != 4'd0}, 32'd0);
    chk("midrst_load_data", bif.load_data, 32'd0);
    chk("midrst_bus_addr", bif.bus_addr, 32'd0);
    chk("midrst_bus_wdata", bif.bus_wdata, 32'd0);
    @(posedge clk);
    #1;
    bif.bus_rvalid = 1'b0;
    idle_cycle(1'b0);
    access(1'b1, 3'd0, 32'h11, 32'hFF, 0, 0, 32'd0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $urandom);
    end
    idle_cycle(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage memory access unit that sits directly downstream of the EX/MEM pipeline register and replaces the single-cycle data memory port. It converts a RISC-V load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) into a word-aligned bus transaction with byte strobes, using a grant/response handshake. It stalls the pipeline until the access completes and returns the load result sign- or zero-extended. Misaligned, illegal and timed-out accesses are reported as faults.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in RESP waiting for bus_rvalid before a timeout fault; legal range 1..65535.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  MEM stage holds a load or store (Ex_Mem_Mem_Read | Ex_Mem_Mem_Write)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 of the access
req_addr  input  32  byte address (the EX/MEM ALU result)
req_wdata  input  32  unshifted store data (rs2)
stall  output  1  hold all upstream pipeline registers this cycle
load_valid  output  1  one-cycle pulse: load_data is valid
load_data  output  32  extended load result
fault  output  1  one-cycle pulse: access failed
fault_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 when fault=0
bus_req  output  1  request to the memory bus
bus_we  output  1  request is a write
bus_addr  output  32  word address: {req_addr[31:2], 2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte-lane write enables; 0000 for reads
bus_gnt  input  1  bus accepts the request this cycle
bus_rvalid  input  1  read response valid
bus_rdata  input  32  read response word

Behaviour:
- Reset (synchronous): state=IDLE, timeout counter=0. All outputs are 0, including load_data. A reset mid-transaction abandons it and bus_req is 0 from the next cycle.
- stall = req_valid && state!=DONE (combinational). In DONE, stall=0 so the pipeline advances at that edge.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If req_valid: latch we, funct3, addr and wdata. Inputs are ignored after this until the next IDLE.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Any other value -> DONE with fault_code 10.
  - Otherwise, if misaligned (half with addr[0]=1, or word with addr[1:0]!=0) -> DONE with fault_code 01.
  - Otherwise -> REQ.
  - If req_valid=0: stay in IDLE.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_wdata and bus_wstrb are driven from registers and held stable until grant.
  - On bus_gnt: a store -> DONE (stores complete at grant); a load -> RESP with counter=0.
- RESP:
  - bus_req=0. Counter increments each cycle.
  - On bus_rvalid: capture and extend the data -> DONE.
  - When counter reaches TIMEOUT_CYCLES-1 with no rvalid -> DONE with fault_code 11. rvalid and timeout in the same cycle: rvalid wins.
- DONE:
  - Lasts one cycle, then IDLE.
  - load_valid=1 only for a load with no fault.
  - fault pulses with the latched fault_code.
  - On a fault, load_data=0; otherwise load_data holds its value until the next DONE.
- bus_gnt outside REQ and bus_rvalid outside RESP are ignored.
- Store lanes (o = addr[1:0]):
  - SB: wstrb = 0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<o, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata = wdata.
- Load extraction: shifted = rdata >> (8*o).
  - LB sign-extends shifted[7:0]; LBU zero-extends it.
  - LH sign-extends shifted[15:0]; LHU zero-extends it.
  - LW passes rdata unchanged.
- Latency, best case (gnt on the first REQ cycle, rvalid on the first RESP cycle): load = 3 stall cycles, store = 2 stall cycles, fault = 1 stall cycle.
- A back-to-back request is accepted in the IDLE cycle directly after DONE.

Test Plan:
- LW addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> stall high 3 cycles, bus_addr=0x100, wstrb=0000, load_valid pulse, load_data=0xDEADBEEF.
- LB addr=0x203 and LBU addr=0x203, rdata=0x80112233 -> load_data=0xFFFFFF80, then 0x00000080.
- SH addr=0x306, wdata=0x1234ABCD, gnt delayed 4 cycles -> bus_req held 4+1 cycles with bus_addr=0x304, wstrb=1100, wdata=0xABCDABCD stable throughout; no load_valid.
- LW addr=0x102 -> no bus_req ever, fault pulse with code 01, load_data=0, stall high 1 cycle; then funct3=011 load -> fault code 10.
- Load granted, no rvalid, TIMEOUT_CYCLES=4 -> fault code 11 after 4 RESP cycles; a later stray rvalid in IDLE is ignored.
- Reset asserted in RESP, then rvalid asserted -> all outputs 0, state IDLE, no load_valid; a following SB addr=0x11, wdata=0xFF completes with wstrb=0010.
